// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the key schedule and cipher blocks.
//   word_t    : 32-bit schedule word
//   NR        : number of AES-128 rounds
//   RCON      : round constants, indexed 1..NR
//   get_rcon  : bounds-safe RCON lookup (returns 0 outside 1..NR)
//   state_t   : inverse key schedule FSM states
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam int NR = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  // Round 0 never steps backwards, so its lookup must not index the table.
  function automatic logic [7:0] get_rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    rc = 8'h00;
    if ((rnd >= 4'd1) && (rnd <= 4'd10)) begin
      rc = RCON[rnd];
    end
    return rc;
  endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// ---------------------------------------------------------------------------
// inv_key_schedule_if
// Load and round-key handshake bundle for inv_key_schedule.
//   start     : load request (master -> slave)
//   key_last  : round-10 key, w40 in [127:96] (master -> slave)
//   rk_ready  : consumer accepts current round key (master -> slave)
//   round_key : current round key (slave -> master)
//   round_num : index of round_key, 10 down to 0 (slave -> master)
//   rk_valid  : round_key/round_num valid (slave -> master)
//   busy      : sequence in progress (slave -> master)
//   done      : one-cycle pulse after round 0 is accepted (slave -> master)
// ---------------------------------------------------------------------------
interface inv_key_schedule_if;

  logic         start;
  logic [127:0] key_last;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         rk_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, key_last, rk_ready,
    input  round_key, round_num, rk_valid, busy, done
  );

  modport slave (
    input  start, key_last, rk_ready,
    output round_key, round_num, rk_valid, busy, done
  );

endinterface

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// (x^254, modulus x^8+x^4+x^3+x+1) followed by the AES affine transform.
//   i_byte : input byte
//   o_byte : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  assign w_inv  = gf_inv(i_byte);
  assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/inv_key_schedule.sv
// ---------------------------------------------------------------------------
// inv_key_schedule
// Sequential AES-128 inverse key schedule. Loads the round-10 key and walks
// the schedule backwards, presenting round keys 10..0 one per handshake.
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : inv_key_schedule_if.slave (start/key_last load, round-key
//           valid/ready stream, busy and done status)
// ---------------------------------------------------------------------------
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  inv_key_schedule_if.slave  bus
);

  state_t       r_state;
  state_t       w_next_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic         r_done;

  logic         w_load;
  logic         w_step;
  logic         w_last;

  word_t        w_a, w_b, w_c, w_d;
  word_t        w_pa, w_pb, w_pc, w_pd;
  word_t        w_rot;
  word_t        w_sub;

  assign {w_a, w_b, w_c, w_d} = r_key;

  // Undo the forward recurrence w[i] = w[i-4] ^ w[i-1] from the last word
  // down; only the first word needs the recovered previous-round last word.
  assign w_pd  = w_d ^ w_c;
  assign w_pc  = w_c ^ w_b;
  assign w_pb  = w_b ^ w_a;
  assign w_rot = {w_pd[23:0], w_pd[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*i +: 8]),
      .o_byte (w_sub[8*i +: 8])
    );
  end

  assign w_pa = w_a ^ w_sub ^ {get_rcon(r_round), 24'h000000};

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = S_EMIT;
          w_load       = 1'b1;
        end
      end
      S_EMIT: begin
        if (bus.rk_ready) begin
          if (r_round == 4'd0) begin
            w_next_state = S_IDLE;
            w_last       = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Key and round only move on load or handshake, so outputs hold under
  // backpressure and keep their last values once back in IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_last;
      if (w_load) begin
        r_key   <= bus.key_last;
        r_round <= 4'(NR);
      end else if (w_step) begin
        r_key   <= {w_pa, w_pb, w_pc, w_pd};
        r_round <= r_round - 4'd1;
      end
    end
  end

  assign bus.round_key = r_key;
  assign bus.round_num = r_round;
  assign bus.rk_valid  = (r_state == S_EMIT);
  assign bus.busy      = (r_state == S_EMIT);
  assign bus.done      = r_done;

endmodule
